// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared helpers and debug state encoding for the registered demux
package demux_pkg;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int valor);
    int resultado;
    int resto;
    resultado = 0;
    resto = valor - 1;
    while (resto > 0) begin
      resultado = resultado + 1;
      resto = resto >> 1;
    end
    return resultado;
  endfunction

  // Occupancy of the holding register, derived from the pending mask
  typedef enum logic [1:0] {
    VACIO    = 2'd0,
    UNICAST  = 2'd1,
    DIFUSION = 2'd2
  } estado_t;

endpackage

// File: rtl/contador_saturado.sv
// rtl/contador_saturado.sv - saturating up-counter with synchronous clear
module contador_saturado #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         borrar,
  input  logic         incrementar,
  output logic [W-1:0] cuenta
);

  // An increment in the same cycle as a clear restarts the count at one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta <= '0;
    end else if (incrementar) begin
      if (borrar) begin
        cuenta <= W'(1);
      end else if (!(&cuenta)) begin
        cuenta <= cuenta + 1'b1;
      end
    end else if (borrar) begin
      cuenta <= '0;
    end
  end

endmodule

// File: rtl/demux_registrado_1an.sv
// rtl/demux_registrado_1an.sv - registered 1-to-N demux with broadcast and selector error tracking
module demux_registrado_1an
  import demux_pkg::*;
#(
  parameter int  ANCHO   = 8,
  parameter int  CANALES = 4,
  localparam int SEL_W   = (clog2(CANALES) < 1) ? 1 : clog2(CANALES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ANCHO-1:0]         entrada_dato,
  input  logic [SEL_W-1:0]         entrada_selector,
  input  logic                     entrada_difusion,
  input  logic                     entrada_valida,
  output logic                     entrada_lista,
  output logic [CANALES*ANCHO-1:0] salida_dato,
  output logic [CANALES-1:0]       salida_valida,
  input  logic [CANALES-1:0]       salida_lista,
  input  logic                     borrar_error,
  output logic                     error_selector,
  output logic [7:0]               descartes
);

  logic [ANCHO-1:0]   dato_reg;
  logic [CANALES-1:0] pendiente;
  logic [CANALES-1:0] restante;
  logic [CANALES-1:0] nuevo;
  logic               acepta;
  logic               en_rango;
  logic               carga;
  logic               descarte;
  estado_t            estado;

  // Handshake decode: ready when every pending channel drains this cycle
  always_comb begin
    restante      = pendiente & ~salida_lista;
    entrada_lista = (restante == '0);
    acepta        = entrada_valida && entrada_lista;
    en_rango      = (int'(entrada_selector) < CANALES);
    nuevo         = '0;
    carga         = 1'b0;
    descarte      = 1'b0;
    if (acepta) begin
      if (entrada_difusion) begin
        nuevo = '1;
        carga = 1'b1;
      end else if (en_rango) begin
        nuevo = CANALES'(1) << entrada_selector;
        carga = 1'b1;
      end else begin
        descarte = 1'b1;
      end
    end
  end

  // Pending mask: drain completed channels, merge the newly accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendiente <= '0;
    end else begin
      pendiente <= restante | nuevo;
    end
  end

  // Holding register only loads on a word that has at least one destination
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dato_reg <= '0;
    end else if (carga) begin
      dato_reg <= entrada_dato;
    end
  end

  // Sticky selector error; a drop in the clear cycle keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_selector <= 1'b0;
    end else if (descarte) begin
      error_selector <= 1'b1;
    end else if (borrar_error) begin
      error_selector <= 1'b0;
    end
  end

  contador_saturado #(
    .W(8)
  ) u_descartes (
    .clk         (clk),
    .rst         (rst),
    .borrar      (borrar_error),
    .incrementar (descarte),
    .cuenta      (descartes)
  );

  // Output fan-out: every channel sees the held word, valid is the pending mask
  always_comb begin
    salida_valida = pendiente;
    salida_dato   = {CANALES{dato_reg}};
  end

  // Debug view of occupancy
  always_comb begin
    if (pendiente == '0) begin
      estado = VACIO;
    end else if ($onehot(pendiente)) begin
      estado = UNICAST;
    end else begin
      estado = DIFUSION;
    end
  end

  a_vacio_listo : assert property (@(posedge clk) disable iff (rst)
    (estado == VACIO) |-> entrada_lista);

endmodule

// File: tb/tb_demux_registrado_1an.sv
// tb/tb_demux_registrado_1an.sv - self-checking bench for the registered 1-to-N demux
module tb_demux_registrado_1an;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance a: 4 channels
  logic [7:0]  a_dato = '0;
  logic [1:0]  a_sel = '0;
  logic        a_dif = 1'b0;
  logic        a_val = 1'b0;
  logic        a_lista;
  logic [31:0] a_sdato;
  logic [3:0]  a_sval;
  logic [3:0]  a_slista = '0;
  logic        a_borrar = 1'b0;
  logic        a_err;
  logic [7:0]  a_desc;

  // Instance b: 3 channels, selector value 3 is out of range
  logic [7:0]  b_dato = '0;
  logic [1:0]  b_sel = '0;
  logic        b_dif = 1'b0;
  logic        b_val = 1'b0;
  logic        b_lista;
  logic [23:0] b_sdato;
  logic [2:0]  b_sval;
  logic [2:0]  b_slista = '0;
  logic        b_borrar = 1'b0;
  logic        b_err;
  logic [7:0]  b_desc;

  demux_registrado_1an #(.ANCHO(8), .CANALES(4)) dut_a (
    .clk(clk), .rst(rst),
    .entrada_dato(a_dato), .entrada_selector(a_sel), .entrada_difusion(a_dif),
    .entrada_valida(a_val), .entrada_lista(a_lista),
    .salida_dato(a_sdato), .salida_valida(a_sval), .salida_lista(a_slista),
    .borrar_error(a_borrar), .error_selector(a_err), .descartes(a_desc)
  );

  demux_registrado_1an #(.ANCHO(8), .CANALES(3)) dut_b (
    .clk(clk), .rst(rst),
    .entrada_dato(b_dato), .entrada_selector(b_sel), .entrada_difusion(b_dif),
    .entrada_valida(b_val), .entrada_lista(b_lista),
    .salida_dato(b_sdato), .salida_valida(b_sval), .salida_lista(b_slista),
    .borrar_error(b_borrar), .error_selector(b_err), .descartes(b_desc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (a_sval !== 4'b0000 || a_lista !== 1'b1 || a_sdato !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_a: sval=%b lista=%b sdato=%h, want 0000/1/0", a_sval, a_lista, a_sdato);
    end
    vectors++;
    if (b_err !== 1'b0 || b_desc !== 8'd0 || a_err !== 1'b0 || a_desc !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_err: a=%b/%0d b=%b/%0d, want 0/0", a_err, a_desc, b_err, b_desc);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_unicast();
    for (int s = 0; s < 4; s++) begin
      a_dato = 8'hA5; a_sel = 2'(s); a_val = 1'b1; a_slista = 4'b1111;
      #1;
      vectors++;
      if (a_lista !== 1'b1) begin
        miscompares++;
        $display("FAIL unicast_lista sel=%0d: got %b want 1", s, a_lista);
      end
      step();
      vectors++;
      if (a_sval !== (4'b0001 << s) || a_sdato[s*8 +: 8] !== 8'hA5) begin
        miscompares++;
        $display("FAIL unicast_out sel=%0d: sval=%b slice=%h want %b/a5", s, a_sval, a_sdato[s*8 +: 8], 4'b0001 << s);
      end
    end
    a_val = 1'b0;
    step();
    vectors++;
    if (a_sval !== 4'b0000) begin
      miscompares++;
      $display("FAIL unicast_drain: sval=%b want 0000", a_sval);
    end
  endtask

  task automatic test_stall();
    a_slista = 4'b1011; a_dato = 8'h3C; a_sel = 2'd2; a_val = 1'b1;
    step();
    a_dato = 8'h77; a_sel = 2'd0;
    #1;
    vectors++;
    if (a_lista !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_lista: got %b want 0", a_lista);
    end
    step();
    vectors++;
    if (a_sval !== 4'b0100 || a_sdato[23:16] !== 8'h3C) begin
      miscompares++;
      $display("FAIL stall_hold: sval=%b slice2=%h want 0100/3c", a_sval, a_sdato[23:16]);
    end
    a_slista = 4'b1111;
    #1;
    vectors++;
    if (a_lista !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release_lista: got %b want 1", a_lista);
    end
    step();
    vectors++;
    if (a_sval !== 4'b0001 || a_sdato[7:0] !== 8'h77) begin
      miscompares++;
      $display("FAIL stall_second: sval=%b slice0=%h want 0001/77", a_sval, a_sdato[7:0]);
    end
    a_val = 1'b0;
    step();
  endtask

  task automatic test_broadcast();
    a_dif = 1'b1; a_dato = 8'h5A; a_val = 1'b1; a_slista = 4'b0101;
    step();
    a_val = 1'b0; a_dif = 1'b0;
    vectors++;
    if (a_sval !== 4'b1111 || a_sdato !== {4{8'h5A}}) begin
      miscompares++;
      $display("FAIL bcast_load: sval=%b sdato=%h want 1111/5a5a5a5a", a_sval, a_sdato);
    end
    #1;
    vectors++;
    if (a_lista !== 1'b0) begin
      miscompares++;
      $display("FAIL bcast_lista1: got %b want 0", a_lista);
    end
    step();
    vectors++;
    if (a_sval !== 4'b1010) begin
      miscompares++;
      $display("FAIL bcast_partial: sval=%b want 1010", a_sval);
    end
    a_slista = 4'b1010;
    #1;
    vectors++;
    if (a_lista !== 1'b1) begin
      miscompares++;
      $display("FAIL bcast_lista2: got %b want 1", a_lista);
    end
    step();
    vectors++;
    if (a_sval !== 4'b0000) begin
      miscompares++;
      $display("FAIL bcast_done: sval=%b want 0000", a_sval);
    end
  endtask

  task automatic test_out_of_range();
    b_sel = 2'd3; b_dif = 1'b0; b_dato = 8'hEE; b_val = 1'b1; b_slista = 3'b111;
    step();
    vectors++;
    if (b_sval !== 3'b000 || b_err !== 1'b1 || b_desc !== 8'd1 || b_sdato !== 24'h0) begin
      miscompares++;
      $display("FAIL oor_first: sval=%b err=%b desc=%0d sdato=%h want 000/1/1/0", b_sval, b_err, b_desc, b_sdato);
    end
    for (int n = 1; n < 300; n++) step();
    vectors++;
    if (b_desc !== 8'd255 || b_lista !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_saturate: desc=%0d lista=%b want 255/1", b_desc, b_lista);
    end
    b_val = 1'b0;
    step();
  endtask

  task automatic test_borrar();
    b_borrar = 1'b1; b_sel = 2'd3; b_val = 1'b1;
    step();
    vectors++;
    if (b_err !== 1'b1 || b_desc !== 8'd1) begin
      miscompares++;
      $display("FAIL borrar_with_drop: err=%b desc=%0d want 1/1", b_err, b_desc);
    end
    b_val = 1'b0;
    step();
    b_borrar = 1'b0;
    vectors++;
    if (b_err !== 1'b0 || b_desc !== 8'd0) begin
      miscompares++;
      $display("FAIL borrar_alone: err=%b desc=%0d want 0/0", b_err, b_desc);
    end
  endtask

  task automatic test_reset_mid();
    a_dif = 1'b1; a_dato = 8'h99; a_val = 1'b1; a_slista = 4'b0001;
    step();
    a_val = 1'b0; a_dif = 1'b0;
    step();
    vectors++;
    if (a_sval !== 4'b1110) begin
      miscompares++;
      $display("FAIL midreset_pre: sval=%b want 1110", a_sval);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (a_sval !== 4'b0000 || a_sdato !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_async: sval=%b sdato=%h want 0000/0", a_sval, a_sdato);
    end
    #2;
    rst = 1'b0;
    a_slista = 4'b0000;
    step();
    vectors++;
    if (a_lista !== 1'b1 || a_sval !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_after: lista=%b sval=%b want 1/0000", a_lista, a_sval);
    end
  endtask

  // Reference model for instance b: per-channel pending flags and one held word
  task automatic test_random();
    bit       m_pend [3];
    int       m_dato;
    bit       m_err;
    int       m_cnt;
    bit       ready;
    logic [2:0] exp_val;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) m_pend[i] = 0;
    m_dato = 0; m_err = 0; m_cnt = 0;
    step();
    for (int cyc = 0; cyc < 400; cyc++) begin
      b_dato   = 8'($urandom);
      b_sel    = 2'($urandom_range(0, 3));
      b_dif    = ($urandom_range(0, 4) == 0);
      b_val    = ($urandom_range(0, 3) != 0);
      b_slista = 3'($urandom);
      b_borrar = ($urandom_range(0, 15) == 0);
      #1;
      ready = 1;
      for (int i = 0; i < 3; i++) if (m_pend[i] && !b_slista[i]) ready = 0;
      vectors++;
      if (b_lista !== ready) begin
        miscompares++;
        $display("FAIL rand_lista cyc=%0d: got %b want %b", cyc, b_lista, ready);
      end
      for (int i = 0; i < 3; i++) if (b_slista[i]) m_pend[i] = 0;
      if (b_borrar) begin
        m_err = 0; m_cnt = 0;
      end
      if (b_val && ready) begin
        if (b_dif) begin
          for (int i = 0; i < 3; i++) m_pend[i] = 1;
          m_dato = b_dato;
        end else if (b_sel < 3) begin
          m_pend[b_sel] = 1;
          m_dato = b_dato;
        end else begin
          m_err = 1;
          m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
      end
      step();
      for (int i = 0; i < 3; i++) exp_val[i] = m_pend[i];
      vectors++;
      if (b_sval !== exp_val) begin
        miscompares++;
        $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, b_sval, exp_val);
      end
      vectors++;
      if (b_sdato !== {3{8'(m_dato)}}) begin
        miscompares++;
        $display("FAIL rand_dato cyc=%0d: got %h want %h", cyc, b_sdato, {3{8'(m_dato)}});
      end
      vectors++;
      if (b_err !== m_err || int'(b_desc) != m_cnt) begin
        miscompares++;
        $display("FAIL rand_err cyc=%0d: err=%b desc=%0d want %b/%0d", cyc, b_err, b_desc, m_err, m_cnt);
      end
    end
    b_val = 1'b0; b_borrar = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_stall();
    test_broadcast();
    test_out_of_range();
    test_borrar();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
